// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC sequencing, combinational program-memory lookup and the IF/ID register.
// Latency: one edge from PC to IF/ID; a redirect costs one bubble; stall holds PC and IF/ID.
module instruction_fetch_unit #(
    parameter int unsigned           MEMORY_DEPTH = 64,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 32'h0040_0000,
    localparam int unsigned          ADDR_WIDTH   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    input  logic [DATA_WIDTH-1:0] instruction_mem_i,
    output logic [ADDR_WIDTH-1:0] rom_address_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ifid_instruction_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_o,
    output logic [DATA_WIDTH-1:0] ifid_pc_plus4_o,
    output logic                  ifid_valid_o,
    output logic                  misaligned_o,
    output logic [DATA_WIDTH-1:0] fetch_count_o
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
    logic                  ifid_vld_q, ifid_vld_d;
    logic                  misaligned_q, misaligned_d;
    logic [DATA_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_offset;
    logic [DATA_WIDTH-1:0] branch_pc;

    assign pc_plus4  = pc_q + DATA_WIDTH'(4);
    assign pc_offset = pc_q - TEXT_BASE;
    assign branch_pc = {branch_target_i[DATA_WIDTH-1:2], 2'b00};

    // Out-of-range PCs simply alias into the memory by truncation.
    assign rom_address_o = ADDR_WIDTH'(pc_offset >> 2);

    always_comb begin
        pc_d         = pc_plus4;
        misaligned_d = branch_taken_i && (branch_target_i[1:0] != 2'b00);
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_vld_d   = ifid_vld_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (branch_taken_i) begin
            pc_d = branch_pc;
        end else if (stall_i) begin
            pc_d = pc_q;
        end

        // A redirect or flush outranks stall so a stalled stage can still be squashed.
        if (branch_taken_i || flush_i) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc_d    = '0;
            ifid_pc4_d   = '0;
            ifid_vld_d   = 1'b0;
        end else if (!stall_i) begin
            ifid_instr_d = instruction_mem_i;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_vld_d   = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= TEXT_BASE;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_vld_q   <= 1'b0;
            misaligned_q <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_vld_q   <= ifid_vld_d;
            misaligned_q <= misaligned_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign pc_o               = pc_q;
    assign ifid_instruction_o = ifid_instr_q;
    assign ifid_pc_o          = ifid_pc_q;
    assign ifid_pc_plus4_o    = ifid_pc4_q;
    assign ifid_valid_o       = ifid_vld_q;
    assign misaligned_o       = misaligned_q;
    assign fetch_count_o      = fetch_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomised bench for instruction_fetch_unit with a scoreboard of expected fetch state.
module tb_instruction_fetch_unit;

    localparam logic [31:0] TB_BASE = 32'h0040_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] instruction_mem_i;
    logic [5:0]  rom_address_o;
    logic [31:0] pc_o, ifid_instruction_o, ifid_pc_o, ifid_pc_plus4_o, fetch_count_o;
    logic        ifid_valid_o, misaligned_o;

    logic [31:0] rom [64];
    assign instruction_mem_i = rom[rom_address_o];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .branch_taken_i    (branch_taken_i),
        .branch_target_i   (branch_target_i),
        .instruction_mem_i (instruction_mem_i),
        .rom_address_o     (rom_address_o),
        .pc_o              (pc_o),
        .ifid_instruction_o(ifid_instruction_o),
        .ifid_pc_o         (ifid_pc_o),
        .ifid_pc_plus4_o   (ifid_pc_plus4_o),
        .ifid_valid_o      (ifid_valid_o),
        .misaligned_o      (misaligned_o),
        .fetch_count_o     (fetch_count_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] cnt;
        logic        vld;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        logic [31:0] off;
        off = (pc - TB_BASE) >> 2;
        return {26'd0, off[5:0]} + 32'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        exp_t        e;
        logic [31:0] off;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
        end else begin
            e   = sb_q.pop_front();
            off = (e.pc - TB_BASE) >> 2;
            chk({tag, ".pc"},    pc_o, e.pc);
            chk({tag, ".rom"},   {26'd0, rom_address_o}, {26'd0, off[5:0]});
            chk({tag, ".instr"}, ifid_instruction_o, e.instr);
            chk({tag, ".ipc"},   ifid_pc_o, e.ipc);
            chk({tag, ".ipc4"},  ifid_pc_plus4_o, e.ipc4);
            chk({tag, ".vld"},   {31'd0, ifid_valid_o}, {31'd0, e.vld});
            chk({tag, ".mis"},   {31'd0, misaligned_o}, {31'd0, e.mis});
            chk({tag, ".cnt"},   fetch_count_o, e.cnt);
        end
    endtask

    task automatic step(input logic st, input logic fl, input logic br,
                        input logic [31:0] tgt, input string tag);
        exp_t n;
        stall_i         = st;
        flush_i         = fl;
        branch_taken_i  = br;
        branch_target_i = tgt;
        n     = m;
        n.mis = br && (tgt[1:0] != 2'b00);
        n.pc  = br ? {tgt[31:2], 2'b00} : (st ? m.pc : m.pc + 32'd4);
        if (br || fl) begin
            n.instr = NOP;
            n.ipc   = '0;
            n.ipc4  = '0;
            n.vld   = 1'b0;
        end else if (!st) begin
            n.instr = rom_word(m.pc);
            n.ipc   = m.pc;
            n.ipc4  = m.pc + 32'd4;
            n.vld   = 1'b1;
            n.cnt   = m.cnt + 32'd1;
        end
        sb_q.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        branch_taken_i = 1'b0;
        check_state(tag);
    endtask

    // Reset is applied with a live redirect and random stall/flush to prove it wins.
    task automatic do_reset(input int cycles);
        reset           = 1'b1;
        stall_i         = 1'($urandom_range(0, 1));
        flush_i         = 1'($urandom_range(0, 1));
        branch_taken_i  = 1'b1;
        branch_target_i = $urandom | 32'h1;
        repeat (cycles) @(posedge clk);
        #1;
        reset          = 1'b0;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        branch_taken_i = 1'b0;
        m       = '0;
        m.pc    = TB_BASE;
        m.instr = NOP;
        sb_q.delete();
        sb_q.push_back(m);
        check_state("reset");
        chk("reset.pc_const", pc_o, TB_BASE);
        chk("reset.rom_zero", {26'd0, rom_address_o}, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = k + 1;

        do_reset(2);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, "run");
            chk("run.pc_const", pc_o, TB_BASE + 32'(4 * k));
            chk("run.instr_const", ifid_instruction_o, 32'(k));
        end
        chk("run.count_const", fetch_count_o, 32'd4);

        do_reset(1);
        step(1'b0, 1'b0, 1'b0, '0, "pre_stall");
        step(1'b0, 1'b0, 1'b0, '0, "pre_stall");
        chk("pre_stall.pc_const", pc_o, 32'h0040_0008);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, '0, "stall");
            chk("stall.pc_const", pc_o, 32'h0040_0008);
            chk("stall.instr_const", ifid_instruction_o, 32'd2);
            chk("stall.cnt_const", fetch_count_o, 32'd2);
        end
        step(1'b0, 1'b0, 1'b0, '0, "resume");
        chk("resume.pc_const", pc_o, 32'h0040_000C);
        chk("resume.instr_const", ifid_instruction_o, 32'd3);

        step(1'b1, 1'b0, 1'b1, 32'h0040_0020, "br_stall");
        chk("br_stall.pc_const", pc_o, 32'h0040_0020);
        chk("br_stall.rom_const", {26'd0, rom_address_o}, 32'd8);
        chk("br_stall.nop_const", ifid_instruction_o, NOP);
        chk("br_stall.vld_const", {31'd0, ifid_valid_o}, 32'd0);
        chk("br_stall.mis_const", {31'd0, misaligned_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, "br_target");
        chk("br_target.instr_const", ifid_instruction_o, 32'd9);

        step(1'b0, 1'b0, 1'b1, 32'h0040_0022, "misalign");
        chk("misalign.pc_const", pc_o, 32'h0040_0020);
        chk("misalign.mis_const", {31'd0, misaligned_o}, 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, "misalign_end");
        chk("misalign_end.mis_const", {31'd0, misaligned_o}, 32'd0);

        do_reset(1);
        step(1'b0, 1'b0, 1'b0, '0, "pre_flush");
        step(1'b1, 1'b1, 1'b0, '0, "stall_flush");
        chk("stall_flush.pc_const", pc_o, 32'h0040_0004);
        chk("stall_flush.nop_const", ifid_instruction_o, NOP);
        chk("stall_flush.vld_const", {31'd0, ifid_valid_o}, 32'd0);
        chk("stall_flush.cnt_const", fetch_count_o, 32'd1);

        step(1'b0, 1'b0, 1'b1, 32'h0040_0100, "wrap_rom");
        chk("wrap_rom.rom_const", {26'd0, rom_address_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, "wrap_rom_load");
        chk("wrap_rom_load.instr_const", ifid_instruction_o, 32'd1);
        chk("wrap_rom_load.ipc_const", ifid_pc_o, 32'h0040_0100);

        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, "pc_top");
        step(1'b0, 1'b0, 1'b0, '0, "pc_wrap");
        chk("pc_wrap.pc_const", pc_o, 32'd0);
        chk("pc_wrap.ipc4_const", ifid_pc_plus4_o, 32'd0);

        do_reset(1);
        for (int k = 0; k < 60; k++) begin
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 7) == 0),
                 TB_BASE + (32'($urandom_range(0, 90)) << 2) + 32'($urandom_range(0, 3)),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
